// File: rtl/seq_divider_ctrl_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
interface seq_divider_ctrl_if #(parameter int N = 32);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         divByZero;

  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder, divByZero);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder, divByZero);
endinterface

// File: rtl/seq_divider_ctrl.sv
// Sequential unsigned restoring divider: one trial subtraction per clock through a
// single shared N+1-bit adder, start/busy/done handshake toward the ALU.
module nBitAdder #(parameter int W = 33) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carIn,
  output logic [W-1:0] sum,
  output logic         carOut
);
  assign {carOut, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carIn};
endmodule

module seq_divider_ctrl #(parameter int N = 32) (
  input logic               clk,
  input logic               reset,
  seq_divider_ctrl_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [N-1:0]  q, r, d;
  logic [CW-1:0] cnt;
  logic [N-1:0]  quotient, remainder;
  logic          busy, done, dbz;

  logic [N:0]    t, diff;
  logic          cout, no_borrow;
  logic [N-1:0]  q_nx, r_nx;

  // Shifted partial remainder is < 2*D, so N+1 bits never overflow.
  assign t = {r, q[N-1]};

  nBitAdder #(.W(N+1)) u_add (
    .a      (t),
    .b      (~{1'b0, d}),
    .carIn  (1'b1),
    .sum    (diff),
    .carOut (cout)
  );

  // diff[N] is always 0 when there is no borrow; folding it in is logically a no-op.
  assign no_borrow = cout & ~diff[N];
  assign q_nx      = {q[N-2:0], no_borrow};
  assign r_nx      = no_borrow ? diff[N-1:0] : t[N-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      q         <= '0;
      r         <= '0;
      d         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy <= 1'b1;
            if (bus.divisor != '0) begin
              q     <= bus.dividend;
              r     <= '0;
              d     <= bus.divisor;
              cnt   <= CW'(N-1);
              dbz   <= 1'b0;
              state <= RUN;
            end else begin
              quotient  <= '1;
              remainder <= bus.dividend;
              dbz       <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        RUN: begin
          q   <= q_nx;
          r   <= r_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            quotient  <= q_nx;
            remainder <= r_nx;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.quotient  = quotient;
  assign bus.remainder = remainder;
  assign bus.divByZero = dbz;
endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Directed + randomized bench for seq_divider_ctrl (N=8) against an arithmetic model.
module tb_seq_divider_ctrl;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [N-1:0] mq, mr;
  logic         mz;

  seq_divider_ctrl_if #(.N(N)) bus ();
  seq_divider_ctrl #(.N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain division; divide-by-zero yields all ones and the dividend.
  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == 0) begin mq = '1; mr = a; mz = 1'b1; end
    else begin mq = a / b; mr = a % b; mz = 1'b0; end
  endtask

  task automatic wait_done(input int start_lat, input int exp_lat, input string tag);
    int lat;
    lat = start_lat;
    while (!bus.done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic check_results(input string tag);
    chk({tag, "_q"}, bus.quotient, mq);
    chk({tag, "_r"}, bus.remainder, mr);
    chk({tag, "_dbz"}, bus.divByZero, mz);
    @(posedge clk); #1;
    chk({tag, "_done_clr"}, bus.done, 0);
    chk({tag, "_busy_clr"}, bus.busy, 0);
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, "_busy"}, bus.busy, 1);
    if (b != 0) begin
      chk({tag, "_hold_q"}, bus.quotient, mq);
      chk({tag, "_early_done"}, bus.done, 0);
    end
    wait_done(0, (b == 0) ? 0 : N, tag);
    model(a, b);
    check_results(tag);
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    reset = 1'b1;
    mq = '0; mr = '0; mz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_q", bus.quotient, 0);
    chk("rst_r", bus.remainder, 0);
    chk("rst_dbz", bus.divByZero, 0);

    run_op(8'd100, 8'd7,   "t1_100_7");
    run_op(8'd255, 8'd1,   "t2_255_1");
    run_op(8'd255, 8'd255, "t2_255_255");
    run_op(8'd3,   8'd10,  "t3_3_10");
    run_op(8'd0,   8'd9,   "t3_0_9");
    run_op(8'd5,   8'd0,   "t4_5_0");
    run_op(8'd6,   8'd3,   "t4_6_3");

    // start pulsed while busy must be dropped
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = 8'd1; bus.divisor = 8'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(3, N, "t5_200_9");
    model(8'd200, 8'd9);
    check_results("t5_200_9");

    // reset mid-RUN discards everything
    bus.start = 1'b1; bus.dividend = 8'd77; bus.divisor = 8'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mq = '0; mr = '0; mz = 1'b0;
    chk("t6_busy", bus.busy, 0);
    chk("t6_done", bus.done, 0);
    chk("t6_q", bus.quotient, 0);
    chk("t6_r", bus.remainder, 0);
    chk("t6_dbz", bus.divByZero, 0);
    run_op(8'd77, 8'd5, "t6_77_5");

    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      run_op(ra, rb, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
